// File: rtl/alu_pkg.sv
// alu_pkg: op codes, flag bit indices and arbiter state shared by the ALU arbiter
package alu_pkg;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam int FLG_LT   = 0;
  localparam int FLG_EQ   = 1;
  localparam int FLG_GT   = 2;
  localparam int FLG_COUT = 3;
  localparam int FLG_OVF  = 4;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
  function automatic logic op_legal(input logic [2:0] op);
    return op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT};
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way grant logic; round-robin, or fixed priority to requester 0 when ALU_ARB_FIXED_PRIO_EN is defined
module rr_arb2
  import alu_pkg::*;
(
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic       clk,
  input  logic       rst_n,
`endif
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);
`ifdef ALU_ARB_FIXED_PRIO_EN
  // requester 0 wins every tie
  always_comb o_gnt = !i_en ? 2'b00 : i_req[0] ? 2'b01 : {i_req[1], 1'b0};
`else
  logic r_ptr;
  // r_ptr names the requester that wins a tie; a lone requester always wins
  always_comb o_gnt = i_en ? {i_req[1] & (!i_req[0] | r_ptr), i_req[0] & (!i_req[1] | !r_ptr)} : 2'b00;
  // after a grant to i, priority passes to 1-i
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= 1'b0;
    else if (|o_gnt) r_ptr <= o_gnt[0];
`endif
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters (ALU_ARB_FIXED_PRIO_EN selects fixed priority)
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_x,
  input  logic [2*WIDTH-1:0] req_y,
  input  logic [5:0]         req_op,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_z,
  output logic [4:0]         rsp_flags,
  output logic               rsp_err,
  output logic [WIDTH-1:0]   alu_x,
  output logic [WIDTH-1:0]   alu_y,
  output logic [2:0]         alu_c,
  input  logic [WIDTH-1:0]   alu_z,
  input  logic               alu_lt,
  input  logic               alu_eq,
  input  logic               alu_gt,
  input  logic               alu_cout,
  input  logic               alu_ovf,
  output logic               busy,
  output logic [15:0]        grant_cnt0,
  output logic [15:0]        grant_cnt1
);
  arb_state_t       r_state;
  logic             r_g;
  logic [1:0]       w_gnt;
  logic             w_gi;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_x, w_y;
  logic [4:0]       w_flags;
  rr_arb2 u_arb (
`ifndef ALU_ARB_FIXED_PRIO_EN
    .clk   (clk),
    .rst_n (rst_n),
`endif
    .i_req (req_valid),
    .i_en  (r_state == IDLE && rst_n),
    .o_gnt (w_gnt)
  );
  // winner's operands and the ALU flags gathered into response order
  always_comb begin
    req_ready = w_gnt;
    w_gi = w_gnt[1];
    w_op = w_gi ? req_op[5:3] : req_op[2:0];
    w_x = w_gi ? req_x[2*WIDTH-1:WIDTH] : req_x[WIDTH-1:0];
    w_y = w_gi ? req_y[2*WIDTH-1:WIDTH] : req_y[WIDTH-1:0];
    w_flags = '0;
    w_flags[FLG_LT] = alu_lt;
    w_flags[FLG_EQ] = alu_eq;
    w_flags[FLG_GT] = alu_gt;
    w_flags[FLG_COUT] = alu_cout;
    w_flags[FLG_OVF] = alu_ovf;
  end
  assign busy = r_state != IDLE;
  // IDLE -> EXEC -> RESP -> IDLE; illegal ops skip EXEC and leave the ALU inputs untouched
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_g <= 1'b0;
      alu_x <= '0;
      alu_y <= '0;
      alu_c <= '0;
      rsp_valid <= '0;
      rsp_z <= '0;
      rsp_flags <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (|w_gnt) begin
          r_g <= w_gi;
          if (op_legal(w_op)) begin
            alu_x <= w_x;
            alu_y <= w_y;
            alu_c <= w_op;
            r_state <= EXEC;
          end else begin
            rsp_z <= '0;
            rsp_flags <= '0;
            rsp_err <= 1'b1;
            rsp_valid <= w_gnt;
            r_state <= RESP;
          end
        end
        EXEC: begin
          rsp_z <= alu_z;
          rsp_flags <= w_flags;
          rsp_err <= 1'b0;
          rsp_valid <= r_g ? 2'b10 : 2'b01;
          r_state <= RESP;
        end
        RESP: if (rsp_ready[r_g]) begin
          rsp_valid <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  // saturating per-requester accept counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (w_gnt[0] && ~&grant_cnt0) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (w_gnt[1] && ~&grant_cnt1) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
  import alu_pkg::*;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  typedef struct {
    int id;
    logic [15:0] z;
    logic [4:0] f;
    logic e;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = 2'b11;
  logic [31:0] req_x = '0, req_y = '0;
  logic [5:0] req_op = '0;
  logic [15:0] rsp_z, alu_x, alu_y, alu_z, grant_cnt0, grant_cnt1;
  logic [4:0] rsp_flags;
  logic [2:0] alu_c;
  logic rsp_err, alu_lt, alu_eq, alu_gt, alu_cout, alu_ovf, busy;
  logic [16:0] sum, dif;
  exp_t q[$];
  int checks = 0, failures = 0;
  alu_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_x(alu_x), .alu_y(alu_y), .alu_c(alu_c), .alu_z(alu_z), .alu_lt(alu_lt),
    .alu_eq(alu_eq), .alu_gt(alu_gt), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
    .busy(busy), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );
  always #5 clk = ~clk;
  // behavioural ALU: unsigned compare flags, carry/borrow and signed overflow for ADD/SUB
  always_comb begin
    sum = {1'b0, alu_x} + {1'b0, alu_y};
    dif = {1'b0, alu_x} - {1'b0, alu_y};
    alu_z = alu_c == ALU_AND ? alu_x & alu_y : alu_c == ALU_OR ? alu_x | alu_y :
            alu_c == ALU_ADD ? sum[15:0] : alu_c == ALU_SUB ? dif[15:0] :
            alu_c == ALU_SLT ? {15'd0, alu_x < alu_y} : 16'd0;
    alu_cout = alu_c == ALU_ADD ? sum[16] : alu_c == ALU_SUB ? dif[16] : 1'b0;
    alu_ovf = alu_c == ALU_ADD ? (alu_x[15] == alu_y[15]) && (sum[15] != alu_x[15]) :
              alu_c == ALU_SUB ? (alu_x[15] != alu_y[15]) && (dif[15] != alu_x[15]) : 1'b0;
    alu_lt = alu_x < alu_y;
    alu_eq = alu_x == alu_y;
    alu_gt = alu_x > alu_y;
  end
  // monitor: pop one expectation per response handshake; no request may be accepted while a response is pending
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && rsp_valid != 2'b00) begin
      checks++;
      if (req_ready != 2'b00) begin
        failures++;
        $display("FAIL ready_during_rsp: req_ready=%b required 00", req_ready);
      end
    end
    if (rst_n && (rsp_valid & rsp_ready) != 2'b00) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp: valid=%b z=%h", rsp_valid, rsp_z);
      end else begin
        e = q.pop_front();
        if (rsp_valid != 2'(1 << e.id) || rsp_z !== e.z || rsp_flags !== e.f || rsp_err !== e.e) begin
          failures++;
          $display("FAIL rsp: valid=%b z=%h flags=%b err=%b, required valid=%b z=%h flags=%b err=%b",
                   rsp_valid, rsp_z, rsp_flags, rsp_err, 2'(1 << e.id), e.z, e.f, e.e);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask
  task automatic drive(input int i, input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    req_valid[i] = 1'b1;
    if (i == 1) begin
      req_op[5:3] = op; req_x[31:16] = x; req_y[31:16] = y;
    end else begin
      req_op[2:0] = op; req_x[15:0] = x; req_y[15:0] = y;
    end
  endtask
  task automatic push(input int i, input logic [15:0] z, input logic [4:0] f, input logic e);
    q.push_back('{id: i, z: z, f: f, e: e});
  endtask
  // wait (bounded) for the next grant, require it to be requester i, return at accept edge + 1
  task automatic accept(input int i, input bit keep);
    bit done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      #1;
      if (req_ready != 2'b00) begin
        chk($sformatf("grant_req%0d", i), {30'd0, req_ready}, 32'(1 << i));
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL accept_timeout: req%0d never granted", i);
    end
    if (!keep) req_valid[i] = 1'b0;
  endtask
  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      if (!busy && q.size() == 0) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL idle_timeout: busy=%b pending=%0d", busy, q.size());
    end
  endtask
  task automatic pulse_reset();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
  initial begin
    int p, w;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {30'd0, req_ready}, 0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_alu_c", {29'd0, alu_c}, 0);
    chk("rst_cnt0", {16'd0, grant_cnt0}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // legal ADD from requester 0, with latency check
    drive(0, ALU_ADD, 16'h0013, 16'h000B);
    push(0, 16'h001E, 5'b00100, 1'b0);
    accept(0, 1'b0);
    chk("t1_busy", {31'd0, busy}, 1);
    chk("t1_no_valid_yet", {30'd0, rsp_valid}, 0);
    chk("t1_alu_x", {16'd0, alu_x}, 32'h0013);
    chk("t1_alu_y", {16'd0, alu_y}, 32'h000B);
    chk("t1_alu_c", {29'd0, alu_c}, {29'd0, ALU_ADD});
    @(posedge clk); #1;
    chk("t1_valid", {30'd0, rsp_valid}, 32'b01);
    wait_idle();
    // simultaneous requests after reset: 0 first, then 1
    pulse_reset();
    drive(0, ALU_SUB, 16'h0003, 16'h0001);
    drive(1, ALU_SLT, 16'h000B, 16'h0013);
    push(0, 16'h0002, 5'b00100, 1'b0);
    push(1, 16'h0001, 5'b00001, 1'b0);
    accept(0, 1'b0);
    accept(1, 1'b0);
    wait_idle();
    chk("t2_alu_c", {29'd0, alu_c}, {29'd0, ALU_SLT});
    // illegal op from requester 1: one-cycle response, ALU inputs untouched
    drive(1, 3'b101, 16'h1234, 16'h5678);
    push(1, 16'h0000, 5'b00000, 1'b1);
    accept(1, 1'b0);
    chk("t3_valid", {30'd0, rsp_valid}, 32'b10);
    chk("t3_alu_c_held", {29'd0, alu_c}, {29'd0, ALU_SLT});
    chk("t3_alu_x_held", {16'd0, alu_x}, 32'h000B);
    chk("t3_cnt1", {16'd0, grant_cnt1}, 2);
    wait_idle();
    // carry-out ADD with a 5-cycle response stall while requester 1 waits
    rsp_ready = 2'b10;
    drive(0, ALU_ADD, 16'hFFFF, 16'h0001);
    push(0, 16'h0000, 5'b01100, 1'b0);
    accept(0, 1'b0);
    drive(1, ALU_AND, 16'hF0F0, 16'h0FF0);
    push(1, 16'h00F0, 5'b00100, 1'b0);
    chk("t4_exec_ready", {30'd0, req_ready}, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      chk("t4_stall_valid", {30'd0, rsp_valid}, 32'b01);
      chk("t4_stall_z", {16'd0, rsp_z}, 0);
      chk("t4_stall_flags", {27'd0, rsp_flags}, 32'b01100);
      chk("t4_stall_ready", {30'd0, req_ready}, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 2'b11;
    accept(1, 1'b0);
    wait_idle();
    // reset during EXEC drops the transaction and clears every output at once
    drive(0, ALU_ADD, 16'h0001, 16'h0001);
    accept(0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_valid", {30'd0, rsp_valid}, 0);
    chk("t5_busy", {31'd0, busy}, 0);
    chk("t5_alu_x", {16'd0, alu_x}, 0);
    chk("t5_alu_c", {29'd0, alu_c}, 0);
    chk("t5_flags", {27'd0, rsp_flags}, 0);
    chk("t5_z", {16'd0, rsp_z}, 0);
    chk("t5_cnt0", {16'd0, grant_cnt0}, 0);
    chk("t5_cnt1", {16'd0, grant_cnt1}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, ALU_OR, 16'h00F0, 16'h0F00);
    push(0, 16'h0FF0, 5'b00001, 1'b0);
    accept(0, 1'b0);
    wait_idle();
    chk("t5_cnt0_after", {16'd0, grant_cnt0}, 1);
    // both requesters continuously valid: alternate (or requester 0 only with fixed priority)
    pulse_reset();
    drive(0, ALU_ADD, 16'h0001, 16'h0002);
    drive(1, ALU_SUB, 16'h0005, 16'h0002);
    p = 0;
    for (int k = 0; k < 4; k++) begin
      w = FIXED ? 0 : p;
      push(w, 16'h0003, w == 1 ? 5'b00100 : 5'b00001, 1'b0);
      accept(w, 1'b1);
      p = 1 - w;
    end
    req_valid = 2'b00;
    wait_idle();
    chk("t6_cnt0", {16'd0, grant_cnt0}, FIXED ? 4 : 2);
    chk("t6_cnt1", {16'd0, grant_cnt1}, FIXED ? 0 : 2);
    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 16-bit ALU between two requesters: requester 0 is the execute stage and requester 1 is the address/branch unit. The block arbitrates, latches one operation, drives the ALU operand and op-code inputs, captures the result and flags, and returns them to the winning requester over a valid/ready handshake. It sits between the pipeline front-ends and the combinational ALU, and is the only driver of the ALU inputs.

## Interface
- `WIDTH`, 16, operand/result width; must match the ALU.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 2: per-requester request valid.
- `req_ready` out 2: per-requester accept; at most one bit high per cycle.
- `req_x` in 2*WIDTH: operand x; requester i uses slice [i*WIDTH +: WIDTH].
- `req_y` in 2*WIDTH: operand y, sliced as `req_x`.
- `req_op` in 6: op code, 3 bits per requester.
- `rsp_valid` out 2: response valid, routed to the granted requester only.
- `rsp_ready` in 2: per-requester response accept.
- `rsp_z` out WIDTH: result, shared by both requesters.
- `rsp_flags` out 5: {overflow, c_out, gt, eq, lt}.
- `rsp_err` out 1: illegal op code.
- `alu_x`, `alu_y` out WIDTH each, and `alu_c` out 3: ALU inputs.
- `alu_z` in WIDTH, and `alu_lt`, `alu_eq`, `alu_gt`, `alu_cout`, `alu_ovf` in 1 each: ALU outputs.
- `busy` out 1: high when the state is not IDLE.
- `grant_cnt0`, `grant_cnt1` out 16 each: accepted-transaction counters.

## Operation
- Legal op codes: 000 AND, 001 OR, 010 ADD, 011 SUB, 111 SLT.
- 100–110 are illegal.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- **IDLE**
  - If any `req_valid` is high, pick winner g and drive `req_ready[g]` = 1 combinationally in this cycle.
  - At the clock edge, latch x, y, op and g into registers and go to EXEC.
  - If the op is illegal, go straight to RESP with `rsp_z` = 0, `rsp_flags` = 0, `rsp_err` = 1; the ALU is not driven.
- **EXEC**
  - `alu_x`, `alu_y` and `alu_c` come from the latched registers; all three change in the same cycle.
  - At the clock edge, register `alu_z` and the flags into the `rsp_*` outputs, set `rsp_err` = 0, and go to RESP.
- **RESP**
  - `rsp_valid[g]` = 1, and the `rsp_*` outputs stay stable.
  - When `rsp_ready[g]` is sampled high, go to IDLE.
  - There is no limit on stall length.
- Outside IDLE, `req_ready` is 00. No new request is accepted in the cycle the response completes.
- Arbitration, round-robin:
  - A pointer names the priority requester; its reset value is 0.
  - After a grant to i, the pointer moves to 1−i.
  - A lone valid requester always wins.
- `grant_cntN` increments on every accepted request from requester N (illegal ops included) and saturates at 0xFFFF.
- `alu_x`, `alu_y` and `alu_c` hold their last values outside EXEC.
- `req_x`, `req_y` and `req_op` matter only in the cycle the request is accepted.

## Timing
- Reset value of every output: 0. That covers `req_ready`, `rsp_valid`, `rsp_z`, `rsp_flags`, `rsp_err`, `alu_*`, `busy` and the counters; the state is IDLE and the pointer is 0.
- Latency for a legal op: accept at edge 0, `rsp_valid` high after edge 2. An illegal op responds after edge 1.
- Best-case throughput: one transaction per 3 cycles (illegal op: 2).
- `rst_n` asserted mid-transaction:
  - The transaction is dropped with no response and all outputs clear immediately.
  - Requesters must re-issue after reset.
- A requester lowering `req_valid` before it is accepted is legal.
- Once `rsp_valid` is high, it drops only after the response handshake.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined: requester 0 always wins simultaneous requests and the pointer is not implemented.
- Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

## Structure
- Package `alu_pkg` holds:
  - op-code localparams `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`;
  - flag bit indices `FLG_LT` … `FLG_OVF`;
  - the state enum `arb_state_t` {IDLE, EXEC, RESP}.
- Sub-module `rr_arb2` holds the grant logic and pointer, including the macro-dependent fixed-priority variant.
- Everything else stays in `alu_arbiter`.

## Test plan
- Requester 0: ADD, x=0x0013, y=0x000B -> after 3 edges, `rsp_valid` = 01, `rsp_z` = 0x001E, flags lt=0, gt=1, eq=0, `rsp_err` = 0.
- Both valid after reset with SUB 3−1 and SLT 0x000B/0x0013 -> requester 0 is served first with z=0x0002; requester 1 is served next with z=0x0001.
- Requester 1 issues op 101 -> `rsp_z` = 0x0000 and `rsp_err` = 1 after 2 edges; `alu_c` is unchanged; `grant_cnt1` increments.
- ADD 0xFFFF+0x0001 with `rsp_ready` held low for 5 cycles -> `rsp_z` = 0x0000 with `c_out` = 1, held stable; `req_ready` stays 00 throughout.
- `rst_n` pulsed low during EXEC -> all outputs are 0 the same cycle; no `rsp_valid`; the next request is accepted normally.
- Build with `ALU_ARB_FIXED_PRIO_EN` and both requesters valid continuously -> requester 0 wins every arbitration; `grant_cnt1` stays 0.
